// File: rtl/scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : scan_decoder
// Brief    : Registered one-hot line decoder with direct-load and auto-scan
//            modes. Optional macro SCAN_BLANK_EN inserts a blank cycle
//            between scanned lines to suppress ghosting on the LED matrix.
// Revision : 1.0 - initial release
// ============================================================================
module scan_decoder #(
    parameter int SEL_W = 5,
    parameter int DIV_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  load,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DIV_W-1:0]      div,
    output logic [2**SEL_W-1:0]   out,
    output logic [SEL_W-1:0]      idx,
    output logic                  valid,
    output logic                  frame_start
);

    localparam int N = 2**SEL_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2,
        BLANK  = 2'd3
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   cnt;
    logic [SEL_W-1:0]   nxt_idx;
    logic [N-1:0]       sel_hot;
    logic [N-1:0]       nxt_hot;
    logic [N-1:0]       idx_hot;
    logic [N-1:0]       line0_hot;

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    assign nxt_idx   = idx + SEL_W'(1);
    assign sel_hot   = onehot(sel);
    assign nxt_hot   = onehot(nxt_idx);
    assign idx_hot   = onehot(idx);
    assign line0_hot = onehot('0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            out         <= '0;
            idx         <= '0;
            valid       <= 1'b0;
            frame_start <= 1'b0;
            cnt         <= '0;
        end else if (!en) begin
            state       <= IDLE;
            out         <= '0;
            idx         <= '0;
            valid       <= 1'b0;
            frame_start <= 1'b0;
            cnt         <= '0;
        end else begin
            frame_start <= 1'b0;
            if (!mode) begin
                // Direct mode: output only changes on a load; leaving scan
                // blanks the output until the controller loads an index.
                state <= DIRECT;
                cnt   <= '0;
                if (load) begin
                    idx   <= sel;
                    out   <= sel_hot;
                    valid <= 1'b1;
                end else if (state != DIRECT) begin
                    idx   <= '0;
                    out   <= '0;
                    valid <= 1'b0;
                end
            end else begin
                case (state)
                    SCAN: begin
                        if (cnt != '0) begin
                            cnt <= cnt - DIV_W'(1);
                        end else begin
`ifdef SCAN_BLANK_EN
                            state <= BLANK;
                            idx   <= nxt_idx;
                            out   <= '0;
                            valid <= 1'b0;
`else
                            idx         <= nxt_idx;
                            out         <= nxt_hot;
                            valid       <= 1'b1;
                            frame_start <= (nxt_idx == '0);
                            cnt         <= div;
`endif
                        end
                    end
`ifdef SCAN_BLANK_EN
                    BLANK: begin
                        // idx already points at the upcoming line
                        state       <= SCAN;
                        out         <= idx_hot;
                        valid       <= 1'b1;
                        frame_start <= (idx == '0);
                        cnt         <= div;
                    end
`endif
                    default: begin
                        // Entry from IDLE or DIRECT always restarts the frame
                        state       <= SCAN;
                        idx         <= '0;
                        out         <= line0_hot;
                        valid       <= 1'b1;
                        frame_start <= 1'b1;
                        cnt         <= div;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_decoder
// Brief    : Self-checking bench for scan_decoder (direct, scan, reset, blank).
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_decoder;

    localparam int SEL_W = 5;
    localparam int DIV_W = 16;
    localparam int N     = 32;

    logic             clk;
    logic             rst;
    logic             en;
    logic             mode;
    logic             load;
    logic [SEL_W-1:0] sel;
    logic [DIV_W-1:0] div;
    logic [N-1:0]     out;
    logic [SEL_W-1:0] idx;
    logic             valid;
    logic             frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    scan_decoder #(.SEL_W(SEL_W), .DIV_W(DIV_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .load        (load),
        .sel         (sel),
        .div         (div),
        .out         (out),
        .idx         (idx),
        .valid       (valid),
        .frame_start (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic             en;
        logic             mode;
        logic             load;
        logic [SEL_W-1:0] sel;
        logic [DIV_W-1:0] div;
        logic [N-1:0]     exp_out;
        logic [SEL_W-1:0] exp_idx;
        logic             chk_idx;
        logic             exp_valid;
        logic             exp_fs;
    } vec_t;

    typedef struct {
        logic [DIV_W-1:0] div;
        logic [SEL_W-1:0] exp_idx;
        logic             exp_valid;
        logic             exp_fs;
    } seq_t;

    vec_t vt [16];
    seq_t sq [12];
    int   sq_len;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; sel = '0; div = '0;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [N-1:0] hot(input logic v, input logic [SEL_W-1:0] i);
        logic [N-1:0] r;
        r = '0;
        if (v) r[i] = 1'b1;
        return r;
    endfunction

    initial begin
        int  period;
        int  line_len;
        int  fs_count;
        bit  found;
        int  t;
        int  line;
        int  ph;
        logic [SEL_W-1:0] e_idx;
        logic             e_v;

        //            en    mode  load  sel    div    exp_out            idx    ci    v     fs
        vt[0]  = '{1'b1, 1'b0, 1'b1, 5'd19, 16'd0, 32'h0008_0000, 5'd19, 1'b1, 1'b1, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 5'd5,  16'd0, 32'h0008_0000, 5'd19, 1'b1, 1'b1, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 5'd0,  16'd0, 32'h0000_0001, 5'd0,  1'b1, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 5'd31, 16'd0, 32'h8000_0000, 5'd31, 1'b1, 1'b1, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 1'b1, 5'd1,  16'd0, 32'h0000_0002, 5'd1,  1'b1, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b1, 5'd7,  16'd0, 32'h0000_0000, 5'd0,  1'b0, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 5'd7,  16'd0, 32'h0000_0000, 5'd0,  1'b0, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 5'd7,  16'd0, 32'h0000_0000, 5'd0,  1'b0, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 5'd12, 16'd0, 32'h0000_1000, 5'd12, 1'b1, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 5'd12, 16'd3, 32'h0000_0001, 5'd0,  1'b1, 1'b1, 1'b1};
        vt[10] = '{1'b1, 1'b1, 1'b1, 5'd9,  16'd3, 32'h0000_0001, 5'd0,  1'b1, 1'b1, 1'b0};
        vt[11] = '{1'b1, 1'b0, 1'b0, 5'd9,  16'd3, 32'h0000_0000, 5'd0,  1'b0, 1'b0, 1'b0};
        vt[12] = '{1'b1, 1'b0, 1'b1, 5'd30, 16'd0, 32'h4000_0000, 5'd30, 1'b1, 1'b1, 1'b0};
        vt[13] = '{1'b1, 1'b1, 1'b1, 5'd2,  16'd0, 32'h0000_0001, 5'd0,  1'b1, 1'b1, 1'b1};
        vt[14] = '{1'b0, 1'b1, 1'b0, 5'd2,  16'd0, 32'h0000_0000, 5'd0,  1'b0, 1'b0, 1'b0};
        vt[15] = '{1'b1, 1'b1, 1'b0, 5'd2,  16'd5, 32'h0000_0001, 5'd0,  1'b1, 1'b1, 1'b1};

        // Dwell change: div is only picked up when a new line starts
`ifdef SCAN_BLANK_EN
        sq[0]  = '{16'd0, 5'd0, 1'b1, 1'b1};
        sq[1]  = '{16'd0, 5'd1, 1'b0, 1'b0};
        sq[2]  = '{16'd4, 5'd1, 1'b1, 1'b0};
        sq[3]  = '{16'd1, 5'd1, 1'b1, 1'b0};
        sq[4]  = '{16'd1, 5'd1, 1'b1, 1'b0};
        sq[5]  = '{16'd1, 5'd1, 1'b1, 1'b0};
        sq[6]  = '{16'd1, 5'd1, 1'b1, 1'b0};
        sq[7]  = '{16'd1, 5'd2, 1'b0, 1'b0};
        sq[8]  = '{16'd1, 5'd2, 1'b1, 1'b0};
        sq[9]  = '{16'd1, 5'd2, 1'b1, 1'b0};
        sq[10] = '{16'd1, 5'd3, 1'b0, 1'b0};
        sq[11] = '{16'd1, 5'd3, 1'b1, 1'b0};
        sq_len = 12;
        line_len = 2;
        div      = 16'd1;
`else
        sq[0]  = '{16'd0, 5'd0, 1'b1, 1'b1};
        sq[1]  = '{16'd0, 5'd1, 1'b1, 1'b0};
        sq[2]  = '{16'd0, 5'd2, 1'b1, 1'b0};
        sq[3]  = '{16'd4, 5'd3, 1'b1, 1'b0};
        sq[4]  = '{16'd1, 5'd3, 1'b1, 1'b0};
        sq[5]  = '{16'd1, 5'd3, 1'b1, 1'b0};
        sq[6]  = '{16'd1, 5'd3, 1'b1, 1'b0};
        sq[7]  = '{16'd1, 5'd3, 1'b1, 1'b0};
        sq[8]  = '{16'd1, 5'd4, 1'b1, 1'b0};
        sq[9]  = '{16'd1, 5'd4, 1'b1, 1'b0};
        sq[10] = '{16'd1, 5'd5, 1'b1, 1'b0};
        sq[11] = '{16'd0, 5'd0, 1'b0, 1'b0};
        sq_len = 11;
        line_len = 3;
        div      = 16'd2;
`endif
        // Both builds use a 3-cycle line slot (visible lines + optional blank)
        period = N * 3;

        // ---- asynchronous reset, checked without a clock edge ----
        rst = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; sel = '0;
        #2 rst = 1'b1;
        #1;
        chk("reset_out",   64'(out),         64'd0);
        chk("reset_idx",   64'(idx),         64'd0);
        chk("reset_valid", 64'(valid),       64'd0);
        chk("reset_fs",    64'(frame_start), 64'd0);
        step();
        rst = 1'b0;

        // ---- table-driven direct/mode-switch vectors ----
        for (int i = 0; i < 16; i++) begin
            en = vt[i].en; mode = vt[i].mode; load = vt[i].load;
            sel = vt[i].sel; div = vt[i].div;
            step();
            chk($sformatf("vec%0d_out", i),   64'(out),         64'(vt[i].exp_out));
            chk($sformatf("vec%0d_valid", i), 64'(valid),       64'(vt[i].exp_valid));
            chk($sformatf("vec%0d_fs", i),    64'(frame_start), 64'(vt[i].exp_fs));
            if (vt[i].chk_idx)
                chk($sformatf("vec%0d_idx", i), 64'(idx), 64'(vt[i].exp_idx));
        end

        // ---- full scan frame plus one wrap ----
        do_reset();
`ifdef SCAN_BLANK_EN
        div = 16'd1;
`else
        div = 16'd2;
`endif
        en = 1'b1; mode = 1'b1; load = 1'b1; sel = 5'd17;
        fs_count = 0;
        for (int c = 1; c <= period + 1; c++) begin
            step();
            t    = (c - 1) % period;
            line = t / 3;
            ph   = t % 3;
            if (ph < line_len) begin
                e_idx = SEL_W'(line);
                e_v   = 1'b1;
            end else begin
                e_idx = SEL_W'((line + 1) % N);
                e_v   = 1'b0;
            end
            if (frame_start) fs_count++;
            chk($sformatf("scan_c%0d_idx", c),   64'(idx),         64'(e_idx));
            chk($sformatf("scan_c%0d_valid", c), 64'(valid),       64'(e_v));
            chk($sformatf("scan_c%0d_out", c),   64'(out),         64'(hot(e_v, e_idx)));
            chk($sformatf("scan_c%0d_fs", c),    64'(frame_start), 64'(t == 0));
        end
        chk("scan_fs_count", 64'(fs_count), 64'd2);

        // ---- dwell change takes effect only at the next line ----
        do_reset();
        en = 1'b1; mode = 1'b1; load = 1'b0;
        for (int k = 0; k < sq_len; k++) begin
            div = sq[k].div;
            step();
            chk($sformatf("dwell%0d_idx", k),   64'(idx),         64'(sq[k].exp_idx));
            chk($sformatf("dwell%0d_valid", k), 64'(valid),       64'(sq[k].exp_valid));
            chk($sformatf("dwell%0d_fs", k),    64'(frame_start), 64'(sq[k].exp_fs));
        end

        // ---- asynchronous reset in the middle of a scan at idx 7 ----
        do_reset();
        en = 1'b1; mode = 1'b1; div = 16'd0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            step();
            if (valid && idx == 5'd7) found = 1'b1;
        end
        chk("reach_idx7", 64'(found), 64'd1);
        rst = 1'b1;
        #2;
        chk("midrst_out",   64'(out),         64'd0);
        chk("midrst_idx",   64'(idx),         64'd0);
        chk("midrst_valid", 64'(valid),       64'd0);
        chk("midrst_fs",    64'(frame_start), 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("restart_idx",   64'(idx),         64'd0);
        chk("restart_out",   64'(out),         64'd1);
        chk("restart_valid", 64'(valid),       64'd1);
        chk("restart_fs",    64'(frame_start), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
